// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings, default widths and grant selection for mem_port_arbiter
package mem_port_arbiter_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_DM = 2'd1;
    localparam logic [1:0] ST_GNT_IF = 2'd2;

    // Data wins unless the starvation guard forces the pending fetch through.
    function automatic logic [1:0] pick_grant(input logic dm_elig,
                                              input logic if_elig,
                                              input logic force_if);
        logic [1:0] gnt;
        gnt = ST_IDLE;
        if (force_if && if_elig) begin
            gnt = ST_GNT_IF;
        end else if (dm_elig) begin
            gnt = ST_GNT_DM;
        end else if (if_elig) begin
            gnt = ST_GNT_IF;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating fetch-starvation counter, built only with ARB_STARVE_GUARD_EN
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == W'(LIMIT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority (data over fetch) arbiter onto one single-ported memory
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          stall_if,
    output logic          stall_dm
);

    logic [1:0] state;
    logic [1:0] gnt;
    logic       dm_elig;
    logic       if_elig;
    logic       force_if;

    // A port whose ack is high this cycle is finishing, not asking again.
    assign dm_elig = dm_req & ~dm_ack;
    assign if_elig = if_req & ~if_ack;

`ifdef ARB_STARVE_GUARD_EN
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    assign starve_inc = (state == ST_IDLE) && (gnt == ST_GNT_DM) && if_req;
    assign starve_clr = (state == ST_IDLE) && (gnt == ST_GNT_IF);

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(starve_inc),
        .clr(starve_clr),
        .sat(starve_sat)
    );

    assign force_if = starve_sat;
`else
    assign force_if = 1'b0;
`endif

    assign gnt = pick_grant(dm_elig, if_elig, force_if);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt == ST_GNT_DM) begin
                        state     <= ST_GNT_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (gnt == ST_GNT_IF) begin
                        state     <= ST_GNT_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ST_GNT_DM: begin
                    if (mem_rdy) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        dm_ack   <= 1'b1;
                        dm_rdata <= mem_we ? '0 : mem_rdata;
                    end
                end
                ST_GNT_IF: begin
                    if (mem_rdy) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if = if_req & ~if_ack;
    assign stall_dm = dm_req & ~dm_ack;

endmodule
